// File: rtl/narrowing_serializer.sv
// -----------------------------------------------------------------------------
// narrowing_serializer
//
// Purpose:
//   Takes one 32-bit word over a valid/ready handshake and sends it out on a
//   16-bit bus. Split mode (mode=0) sends two beats: the low half, then the
//   high half. Narrow mode (mode=1) sends only the low half. In narrow mode,
//   with NARROW_OVF_EN defined, the dropped upper half is also checked. It
//   must equal the sign extension (sel=1) or the zero extension (sel=0) of
//   the low half.
//
// Configuration macro:
//   NARROW_OVF_EN - when defined, builds the overflow compare and a
//                   saturating counter, and adds the ovf / ovf_cnt ports.
//
// Handshake rule (both sides):
//   A transfer happens on a rising edge where valid and ready are both high
//   and rst is low. A valid source holds its data stable until the transfer.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   word on a is offered
//   in_ready   out  block can accept a word (high only in IDLE)
//   a          in   32-bit input word
//   sel        in   overflow-check extension type: 1 = sign, 0 = zero
//   mode       in   0 = split (2 beats), 1 = narrow (1 beat)
//   out_valid  out  beat on out is valid
//   out_ready  in   consumer takes the beat
//   out        out  16-bit output half-word
//   last       out  current beat is the final beat of the word
//   ovf        out  narrow truncation loses information (NARROW_OVF_EN)
//   ovf_cnt    out  saturating count of overflowing narrow beats
//                   (NARROW_OVF_EN)
// -----------------------------------------------------------------------------
module narrowing_serializer (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic        sel,
   input  logic        mode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out,
   output logic        last
`ifdef NARROW_OVF_EN
   ,
   output logic        ovf,
   output logic [7:0]  ovf_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2
   } state_e;

   state_e      state_q;
   logic [31:0] word_q;
   logic        sel_q;
   logic        mode_q;
   logic        in_ready_q;
   logic        out_valid_q;
   logic        last_q;

   // Single FSM block. The handshake outputs are registered together with
   // the state, so in_ready never depends combinationally on out_ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         word_q      <= 32'h0000_0000;
         sel_q       <= 1'b0;
         mode_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         last_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  state_q     <= ST_LO;
                  word_q      <= a;
                  sel_q       <= sel;
                  mode_q      <= mode;
                  in_ready_q  <= 1'b0;
                  out_valid_q <= 1'b1;
                  last_q      <= mode;
               end
            end
            ST_LO: begin
               if (out_ready) begin
                  if (mode_q) begin
                     state_q     <= ST_IDLE;
                     in_ready_q  <= 1'b1;
                     out_valid_q <= 1'b0;
                     last_q      <= 1'b0;
                  end else begin
                     state_q <= ST_HI;
                     last_q  <= 1'b1;
                  end
               end
            end
            ST_HI: begin
               if (out_ready) begin
                  state_q     <= ST_IDLE;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
                  last_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               last_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign last      = last_q;

   // The half select is decoded from registered state only. It reads 0
   // whenever no beat is on the bus.
   always_comb begin
      out = 16'h0000;
      case (state_q)
         ST_LO:   out = word_q[15:0];
         ST_HI:   out = word_q[31:16];
         default: out = 16'h0000;
      endcase
   end

`ifdef NARROW_OVF_EN
   logic       ovf_hit;
   logic       ovf_take;
   logic [7:0] ovf_cnt_q;
   logic [7:0] ovf_cnt_d;

   // The upper half must be a pure extension of the low half. Otherwise
   // truncating the word loses information.
   always_comb begin
      ovf_hit = 1'b0;
      if ((state_q == ST_LO) && mode_q) begin
         if (sel_q) ovf_hit = (word_q[31:16] != {16{word_q[15]}});
         else       ovf_hit = (word_q[31:16] != 16'h0000);
      end
   end

   // Count only beats actually handed off, not stalled cycles.
   assign ovf_take = ovf_hit && out_ready;

   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (ovf_take && (ovf_cnt_q != 8'hFF)) ovf_cnt_d = ovf_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) ovf_cnt_q <= 8'h00;
      else     ovf_cnt_q <= ovf_cnt_d;
   end

   assign ovf     = ovf_hit;
   assign ovf_cnt = ovf_cnt_q;
`else
   // sel is still captured so the register map matches both builds. Without
   // the overflow check it has no consumer.
   logic unused_sel;
   assign unused_sel = sel_q;
`endif

endmodule
